ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter WORD_WIDTH, default 20: bits per configuration word; matches the routing channel width.
REQ-002 Parameter CHAIN_LENGTH, default 40: number of configuration flip-flops in the target ccff chain.
REQ-003 Parameter CNT_WIDTH, default 16: width of the internal bit counter; CHAIN_LENGTH SHALL be less than 2^CNT_WIDTH.
REQ-004 prog_clk  input  1  programming clock; the only clock in the block.
REQ-005 pReset  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a chain load.
REQ-007 abort  input  1  terminates a load in progress.
REQ-008 cfg_valid  input  1  cfg_word holds a valid configuration word.
REQ-009 cfg_word  input  [0:WORD_WIDTH-1]  configuration word; bit 0 is shifted first.
REQ-010 cfg_ready  output  1  loader accepts cfg_word this cycle.
REQ-011 ccff_head  output  1  serial data into the chain head.
REQ-012 ccff_shift_en  output  1  chain shift enable; the chain captures ccff_head on each prog_clk edge where this is high.
REQ-013 busy  output  1  high in the LOAD state.
REQ-014 done  output  1  sticky; the last load completed all CHAIN_LENGTH bits.
REQ-015 aborted  output  1  sticky; the last load was terminated by abort.

Function
REQ-016 States: IDLE, LOAD, DONE. The state register, holding shift register, bit counters, ccff_head, ccff_shift_en, done and aborted SHALL all be registered on prog_clk.
REQ-017 IDLE or DONE, start=1 -> LOAD; clear done, aborted and the bit counters.
REQ-018 start while in LOAD SHALL be ignored.
REQ-019 cfg_ready = LOAD and words_accepted < ceil(CHAIN_LENGTH/WORD_WIDTH) and (holding register empty, or this cycle shifts the final bit of the held word).
REQ-020 A word is accepted on a cycle with cfg_valid and cfg_ready both high; cfg_word is ignored on every other cycle.
REQ-021 Latency: word accepted in cycle T -> ccff_head=cfg_word[0] with ccff_shift_en=1 in cycle T+1; bit k is presented in cycle T+1+k.
REQ-022 Back-to-back words SHALL produce contiguous ccff_shift_en with no gap cycle.
REQ-023 Holding register empty and no word accepted -> ccff_shift_en=0, ccff_head holds its last value, and no bit is lost or duplicated.
REQ-024 Each cycle with ccff_shift_en=1 increments bits_shifted. When bits_shifted reaches CHAIN_LENGTH, the holding register SHALL empty and any unshifted bits of the final word SHALL be discarded.
REQ-025 The cycle after the CHAIN_LENGTH-th shift cycle: state -> DONE, done=1, ccff_shift_en=0.
REQ-026 abort in LOAD: next cycle state -> IDLE, ccff_shift_en=0, holding register emptied, aborted=1, done=0. abort in IDLE or DONE has no effect.
REQ-027 abort and start in the same cycle: abort SHALL take priority; start SHALL be ignored.
REQ-028 busy=1 exactly while in LOAD; cfg_ready=0 outside LOAD.

Reset
REQ-029 pReset high SHALL immediately force, independent of prog_clk: state=IDLE, ccff_head=0, ccff_shift_en=0, cfg_ready=0, busy=0, done=0, aborted=0, all counters and the holding register cleared.
REQ-030 pReset asserted during LOAD SHALL discard the partial load; no shift occurs after reset until a new start.
REQ-031 The first start is honoured on the first rising edge of prog_clk after pReset deasserts.

Verification
REQ-032 Default parameters; start; words 0xA5A5A and 0x0F0F0 offered back-to-back with cfg_valid held -> 40 contiguous ccff_shift_en cycles, ccff_head follows bit 0..19 of each word in order, done=1 the cycle after the 40th shift.
REQ-033 cfg_valid dropped for 5 cycles after word 1 -> 5-cycle ccff_shift_en gap, exactly 40 shift cycles in total, bit sequence identical to REQ-032.
REQ-034 CHAIN_LENGTH=50 -> exactly 3 words accepted, only bits 0..9 of word 3 shifted, cfg_ready=0 after the third accept, done=1.
REQ-035 abort after 25 shifts -> ccff_shift_en=0 the next cycle, state=IDLE, aborted=1, done=0; a fresh start then completes a full 40-bit load.
REQ-036 start pulsed mid-load -> ignored, bit count unchanged. start and abort in the same cycle -> abort wins.
REQ-037 pReset pulsed asynchronously mid-load (between clock edges) -> all outputs 0 immediately; a subsequent load completes normally.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words into a ccff configuration chain on prog_clk.
// Words are accepted through a valid/ready handshake and shifted out bit 0 first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; also entered after an abort
// LOAD  | accepting words and shifting bits into the chain
// DONE  | all CHAIN_LENGTH bits shifted; waiting for the next start
module ccff_chain_loader #(
    parameter int WORD_WIDTH   = 20,
    parameter int CHAIN_LENGTH = 40,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    input  logic [0:WORD_WIDTH-1] cfg_word,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  ccff_shift_en,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int HOLD_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] NUM_WORDS =
        CNT_WIDTH'((CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LENGTH - 1);

    state_t                state;
    logic [0:WORD_WIDTH-1] hold_reg;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [CNT_WIDTH-1:0]  bits_shifted;
    logic [CNT_WIDTH-1:0]  words_accepted;

    logic hold_empty;
    logic accept;
    logic last_shift;

    // hold_cnt counts bits not yet presented; zero while the final bit of a
    // word is on ccff_head, which is exactly when a new word may be taken
    assign hold_empty = (hold_cnt == '0);
    assign cfg_ready  = (state == ST_LOAD) && (words_accepted < NUM_WORDS) && hold_empty;
    assign accept     = cfg_valid && cfg_ready;
    assign last_shift = ccff_shift_en && (bits_shifted == LAST_BIT);
    assign busy       = (state == ST_LOAD);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state          <= ST_IDLE;
            hold_reg       <= '0;
            hold_cnt       <= '0;
            bits_shifted   <= '0;
            words_accepted <= '0;
            ccff_head      <= 1'b0;
            ccff_shift_en  <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        state          <= ST_LOAD;
                        hold_reg       <= '0;
                        hold_cnt       <= '0;
                        bits_shifted   <= '0;
                        words_accepted <= '0;
                        ccff_shift_en  <= 1'b0;
                        done           <= 1'b0;
                        aborted        <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state         <= ST_IDLE;
                        hold_reg      <= '0;
                        hold_cnt      <= '0;
                        ccff_shift_en <= 1'b0;
                        aborted       <= 1'b1;
                        done          <= 1'b0;
                    end else begin
                        if (ccff_shift_en) begin
                            bits_shifted <= bits_shifted + CNT_WIDTH'(1);
                        end

                        if (last_shift) begin
                            // chain is full: drop whatever is left of the final word
                            state         <= ST_DONE;
                            hold_reg      <= '0;
                            hold_cnt      <= '0;
                            ccff_shift_en <= 1'b0;
                            done          <= 1'b1;
                        end else if (!hold_empty) begin
                            ccff_head     <= hold_reg[0];
                            hold_reg      <= {hold_reg[1:WORD_WIDTH-1], 1'b0};
                            hold_cnt      <= hold_cnt - HOLD_W'(1);
                            ccff_shift_en <= 1'b1;
                        end else if (accept) begin
                            ccff_head      <= cfg_word[0];
                            hold_reg       <= {cfg_word[1:WORD_WIDTH-1], 1'b0};
                            hold_cnt       <= HOLD_W'(WORD_WIDTH - 1);
                            words_accepted <= words_accepted + CNT_WIDTH'(1);
                            ccff_shift_en  <= 1'b1;
                        end else begin
                            ccff_shift_en <= 1'b0;
                        end
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    ccff_shift_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a default 40-bit chain instance and a
// 50-bit chain instance, checked with immediate assertions.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        pReset;
    logic        start, abort, cfg_valid;
    logic [0:19] cfg_word;
    logic        rdy40, head40, sh40, busy40, done40, aborted40;

    logic        start50, abort50, valid50;
    logic [0:19] word50;
    logic        rdy50, head50, sh50, busy50, done50, aborted50;

    ccff_chain_loader dut40 (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .cfg_valid    (cfg_valid),
        .cfg_word     (cfg_word),
        .cfg_ready    (rdy40),
        .ccff_head    (head40),
        .ccff_shift_en(sh40),
        .busy         (busy40),
        .done         (done40),
        .aborted      (aborted40)
    );

    ccff_chain_loader #(.WORD_WIDTH(20), .CHAIN_LENGTH(50), .CNT_WIDTH(16)) dut50 (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start50),
        .abort        (abort50),
        .cfg_valid    (valid50),
        .cfg_word     (word50),
        .cfg_ready    (rdy50),
        .ccff_head    (head50),
        .ccff_shift_en(sh50),
        .busy         (busy50),
        .done         (done50),
        .aborted      (aborted50)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          nshift, first_sh, last_sh, acc40;
    logic [0:63] cap40;
    int          nshift50, acc50;
    logic [0:63] cap50;

    localparam logic [0:19] W1 = 20'hA5A5A;
    localparam logic [0:19] W2 = 20'h0F0F0;
    localparam logic [0:19] W3 = 20'h3C3C3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: count handshakes at the edge, then sample 1ns after it
    task automatic tick();
        if (cfg_valid && rdy40) acc40++;
        if (valid50 && rdy50) acc50++;
        @(posedge prog_clk);
        #1;
        cyc++;
        if (sh40) begin
            if (nshift < 64) cap40[nshift] = head40;
            if (nshift == 0) first_sh = cyc;
            last_sh = cyc;
            nshift++;
        end
        if (sh50) begin
            if (nshift50 < 64) cap50[nshift50] = head50;
            nshift50++;
        end
    endtask

    task automatic clear_capture();
        nshift = 0; first_sh = 0; last_sh = 0; acc40 = 0; cap40 = '0;
    endtask

    // start a load on dut40 and feed W-words; optional gap, abort or mid-load start
    task automatic run_load(input logic [0:19] w1, input logic [0:19] w2, input int gap,
                            input int abort_at, input int start_at, input logic start_too);
        int   gapcnt = 0;
        int   n = 0;
        logic stop = 1'b0;
        clear_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy40), 64'd1);
        chk("start_done_clr", 64'(done40), 64'd0);
        while (!stop && n < 200) begin
            cfg_word  = (acc40 == 0) ? w1 : w2;
            cfg_valid = (acc40 < 2);
            if (acc40 == 1 && rdy40 && gapcnt < gap) begin
                cfg_valid = 1'b0;
                gapcnt++;
            end
            if (sh40 && nshift == abort_at) begin
                abort = 1'b1;
                start = start_too;
                stop  = 1'b1;
            end else if (sh40 && nshift == start_at) begin
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            abort = 1'b0;
            n++;
            if (done40) stop = 1'b1;
        end
        cfg_valid = 1'b0;
        chk("load_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic check_full(input string tag, input logic [0:39] exp, input int gap);
        chk({tag, "_nshift"}, 64'(nshift), 64'd40);
        chk({tag, "_bits"}, 64'(cap40[0:39]), 64'(exp));
        chk({tag, "_gap"}, 64'((last_sh - first_sh + 1) - nshift), 64'(gap));
        chk({tag, "_done"}, 64'(done40), 64'd1);
        chk({tag, "_done_lat"}, 64'(cyc - last_sh), 64'd1);
        chk({tag, "_shift_off"}, 64'(sh40), 64'd0);
        chk({tag, "_busy_off"}, 64'(busy40), 64'd0);
        chk({tag, "_aborted"}, 64'(aborted40), 64'd0);
        chk({tag, "_accepts"}, 64'(acc40), 64'd2);
        chk({tag, "_rdy_off"}, 64'(rdy40), 64'd0);
    endtask

    initial begin
        logic [0:39] exp40;
        logic [0:49] exp50;
        int          n;
        int          hold_n;

        exp40 = {W1, W2};
        exp50 = {W1, W2, W3[0:9]};

        pReset = 1'b1;
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
        start50 = 1'b0; abort50 = 1'b0; valid50 = 1'b0; word50 = '0;
        nshift50 = 0; acc50 = 0; cap50 = '0;
        clear_capture();

        #1;
        chk("rst_outputs", 64'({rdy40, head40, sh40, busy40, done40, aborted40}), 64'd0);
        chk("rst_outputs50", 64'({rdy50, head50, sh50, busy50, done50, aborted50}), 64'd0);
        tick();
        tick();
        pReset = 1'b0;

        // back-to-back words, start on first edge after reset release
        run_load(W1, W2, 0, 0, 0, 1'b0);
        check_full("b2b", exp40, 0);

        // five-cycle valid gap between the words
        run_load(W1, W2, 5, 0, 0, 1'b0);
        check_full("gap5", exp40, 5);

        // abort during the 25th shift cycle
        run_load(W1, W2, 0, 25, 0, 1'b0);
        chk("abort_shift_off", 64'(sh40), 64'd0);
        chk("abort_busy", 64'(busy40), 64'd0);
        chk("abort_flag", 64'(aborted40), 64'd1);
        chk("abort_done", 64'(done40), 64'd0);
        chk("abort_nshift", 64'(nshift), 64'd25);
        chk("abort_bits", 64'(cap40[0:24]), 64'(exp40[0:24]));
        repeat (3) tick();
        chk("abort_quiet", 64'(nshift), 64'd25);
        chk("abort_rdy", 64'(rdy40), 64'd0);

        run_load(W1, W2, 0, 0, 0, 1'b0);
        check_full("after_abort", exp40, 0);

        // start pulsed during the 10th shift is ignored
        run_load(W2, W1, 0, 0, 10, 1'b0);
        check_full("mid_start", {W2, W1}, 0);

        // start and abort together mid-load: abort wins
        run_load(W1, W2, 0, 15, 0, 1'b1);
        chk("sa_busy", 64'(busy40), 64'd0);
        chk("sa_aborted", 64'(aborted40), 64'd1);
        chk("sa_nshift", 64'(nshift), 64'd15);

        // start and abort together in IDLE: start ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_idle_busy", 64'(busy40), 64'd0);
        chk("sa_idle_aborted", 64'(aborted40), 64'd1);

        // asynchronous reset between clock edges mid-load
        clear_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b1; cfg_word = W1;
        repeat (6) tick();
        cfg_valid = 1'b0;
        chk("pre_rst_shift", 64'(sh40), 64'd1);
        hold_n = nshift;
        #2 pReset = 1'b1;
        #1;
        chk("async_rst_out", 64'({rdy40, head40, sh40, busy40, done40, aborted40}), 64'd0);
        tick();
        pReset = 1'b0;
        repeat (3) tick();
        chk("post_rst_quiet", 64'(nshift), 64'(hold_n));
        chk("post_rst_busy", 64'(busy40), 64'd0);
        run_load(W1, W2, 0, 0, 0, 1'b0);
        check_full("after_rst", exp40, 0);

        // 50-bit chain: three words, only bits 0..9 of the third shifted
        nshift50 = 0; acc50 = 0; cap50 = '0;
        start50 = 1'b1;
        tick();
        start50 = 1'b0;
        valid50 = 1'b1;
        n = 0;
        while (!done50 && n < 200) begin
            word50 = (acc50 == 0) ? W1 : ((acc50 == 1) ? W2 : W3);
            tick();
            n++;
        end
        chk("c50_timeout", 64'(n < 200), 64'd1);
        tick();
        valid50 = 1'b0;
        chk("c50_nshift", 64'(nshift50), 64'd50);
        chk("c50_bits", 64'(cap50[0:49]), 64'(exp50));
        chk("c50_accepts", 64'(acc50), 64'd3);
        chk("c50_rdy", 64'(rdy50), 64'd0);
        chk("c50_done", 64'(done50), 64'd1);
        chk("c50_shift_off", 64'(sh50), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
